dm_sized: RTL

Parametrised clocked data memory for the MIPS datapath. Byte-addressed, word-organised storage with sub-word load/store: byte, halfword or word, with load sign/zero extension. Adds a registered one-cycle read and misalignment detection. An optional post-reset zero-fill state machine clears the array. Sits in the MEM stage and serves lw/lh/lhu/lb/lbu/sw/sh/sb.

---
 rtl/dm_sized.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dm_sized.sv
// dm_sized: clocked data memory for the MIPS MEM stage.
//
// Byte-addressed, word-organised storage with byte/halfword/word loads and
// stores. Loads are sign- or zero-extended. Reads return one cycle later.
// Misaligned requests are detected and never write. An optional zero-fill
// sequence clears every word after reset.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req_rd    read request, sampled on clk
//   req_wr    write request, sampled on clk
//   addr      byte address (ADDR_W bits)
//   size      00 byte, 01 halfword, 10 word, 11 reserved (misaligned)
//   sign_ext  1 = sign-extend sub-word load, 0 = zero-extend
//   wdata     store data, right-justified
//   rdata     load data, valid while rvalid=1, held otherwise
//   rvalid    one-cycle pulse one cycle after an accepted read
//   misalign  one-cycle pulse one cycle after a misaligned accepted request
//   busy      high while the zero-fill runs; requests are ignored
module dm_sized #(
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              misalign,
  output logic              busy
);

  localparam int PTR_W = ADDR_W - 2;
  localparam int DEPTH = 1 << PTR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [0:0] ST_INIT  = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  logic [31:0]      mem [DEPTH];
  logic [0:0]       state;
  logic [PTR_W-1:0] ptr;

  logic [PTR_W-1:0] word_idx;
  logic             accept;
  logic             is_misaligned;
  logic             wr_en;
  logic [3:0]       lane_mask;
  logic [31:0]      wlanes;
  logic [31:0]      old_word;
  logic [31:0]      new_word;
  logic [31:0]      rd_word;
  logic [31:0]      shifted;
  logic [31:0]      load_val;

  assign busy     = (state == ST_CLEAR);
  assign word_idx = addr[ADDR_W-1:2];
  assign accept   = (req_rd | req_wr) & ~busy;
  assign wr_en    = accept & req_wr & ~is_misaligned;

  // Alignment check and lane selection. Store data is replicated across
  // all lanes so the lane mask alone picks which bytes land in the word.
  always_comb begin
    is_misaligned = 1'b0;
    lane_mask     = 4'b0000;
    wlanes        = wdata;
    case (size)
      2'b00: begin
        lane_mask = 4'b0001 << addr[1:0];
        wlanes    = {4{wdata[7:0]}};
      end
      2'b01: begin
        is_misaligned = addr[0];
        lane_mask     = addr[1] ? 4'b1100 : 4'b0011;
        wlanes        = {2{wdata[15:0]}};
      end
      2'b10: begin
        is_misaligned = (addr[1:0] != 2'b00);
        lane_mask     = 4'b1111;
      end
      default: begin
        is_misaligned = 1'b1;
      end
    endcase
  end

  // Merge the store into the current word. A combined read+write returns
  // this merged word, which gives write-first behaviour with no stale data.
  always_comb begin
    old_word = mem[word_idx];
    new_word = old_word;
    for (int k = 0; k < 4; k++) begin
      if (lane_mask[k]) begin
        new_word[8*k +: 8] = wlanes[8*k +: 8];
      end
    end
    rd_word = req_wr ? new_word : old_word;
  end

  // Right-justify the addressed lanes and extend. Aligned halfwords have
  // addr[0]=0 and words have addr[1:0]=0, so one byte-granular shift
  // serves every size.
  always_comb begin
    shifted  = rd_word >> {addr[1:0], 3'b000};
    load_val = shifted;
    case (size)
      2'b00:   load_val = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Zero-fill sequencer: one word per cycle, leaving on the edge that
  // clears the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == {PTR_W{1'b1}}) begin
        state <= ST_READY;
      end
    end
  end

  // Response registers. A misaligned read still answers, with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rvalid   <= accept & req_rd;
      misalign <= accept & is_misaligned;
      if (accept & req_rd) begin
        rdata <= is_misaligned ? 32'h0 : load_val;
      end
    end
  end

  // Storage array has no reset; the fill sequencer owns it while busy.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      mem[word_idx] <= new_word;
    end
  end

endmodule
